// File: rtl/w_burn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : w_burn_pkg
// Purpose  : Shared types, constants and helpers for the weight burn-in loader.
// Revision : 1.0  initial release
// ============================================================================
package w_burn_pkg;

  // Width of one stream beat and of one memory bank word
  localparam int BEAT_W = 64;

  // Loader session states; CHK is reachable only when the checksum trailer is built in
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Number of 64-bit banks needed to hold one full weight row
  function automatic int n_bank(input int width);
    return width / BEAT_W;
  endfunction

  // Counter width that stays at least one bit for degenerate sizes
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/w_burn_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : w_burn_loader_if
// Purpose  : Weight stream (valid/ready) plus registered bank write port.
//            master = stream source / memory sink side, slave = loader side.
// Revision : 1.0  initial release
// ============================================================================
interface w_burn_loader_if #(
  parameter int N_BANK = 75,
  parameter int ADDR_W = 9
);

  logic                          s_valid;
  logic [w_burn_pkg::BEAT_W-1:0] s_data;
  logic                          s_ready;
  logic [N_BANK-1:0]             mem_we;
  logic [ADDR_W-1:0]             mem_addr;
  logic [w_burn_pkg::BEAT_W-1:0] mem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/w_burn_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module   : w_burn_addr_ctr
// Purpose  : Bank/row position counter for the burn loader. Bank advances per
//            accepted beat and wraps into the next row; saturates on last beat.
// Revision : 1.0  initial release
// ============================================================================
module w_burn_addr_ctr #(
  parameter int N_BANK = 75,
  parameter int DEPTH  = 512,
  parameter int BANK_W = 7,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [BANK_W-1:0] bank_o,
  output logic [ADDR_W-1:0] row_o,
  output logic              last_o
);

  logic [BANK_W-1:0] bank_q;
  logic [ADDR_W-1:0] row_q;
  logic              bank_last;
  logic              row_last;

  assign bank_last = (bank_q == BANK_W'(N_BANK - 1));
  assign row_last  = (row_q == ADDR_W'(DEPTH - 1));
  assign last_o    = bank_last && row_last;
  assign bank_o    = bank_q;
  assign row_o     = row_q;

  // Position update: clear at session start, advance on accept, hold at the final slot
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bank_q <= '0;
      row_q  <= '0;
    end else if (clr_i) begin
      bank_q <= '0;
      row_q  <= '0;
    end else if (inc_i && !last_o) begin
      if (bank_last) begin
        bank_q <= '0;
        row_q  <= row_q + 1'b1;
      end else begin
        bank_q <= bank_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/w_burn_loader.sv
`default_nettype none
// ============================================================================
// Module   : w_burn_loader
// Purpose  : Burn-in writer for the banked weight memory. Streams 64-bit beats
//            bank-major into N_BANK banks of DATA_DEPTH rows and raises burned
//            when every slot has been written.
// Options  : W_BURN_CHECKSUM_EN - expect one XOR checksum trailer beat after
//            the data; burned only if it matches, err on mismatch.
// Revision : 1.0  initial release
// ============================================================================
module w_burn_loader
  import w_burn_pkg::*;
#(
  parameter int DATA_WIDTH = 4800,
  parameter int DATA_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              burn_in_en,
  w_burn_loader_if.slave    bus,
  output logic              busy,
  output logic              burned,
  output logic              err
);

  localparam int N_BANK = n_bank(DATA_WIDTH);
  localparam int BANK_W = clog2_min1(N_BANK);
  localparam int ADDR_W = clog2_min1(DATA_DEPTH);

  state_e              state_q, state_d;
  logic                en_q;
  logic                en_rise;
  logic [N_BANK-1:0]   we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]   wdata_q, wdata_d;
  logic                burned_q, burned_d;
  logic                err_q, err_d;
  logic                s_ready_w;
  logic                ctr_clr;
  logic                ctr_inc;
  logic [BANK_W-1:0]   bank;
  logic [ADDR_W-1:0]   row;
  logic                last;
  logic [N_BANK-1:0]   bank_oh;
`ifdef W_BURN_CHECKSUM_EN
  logic [BEAT_W-1:0]   csum_q, csum_d;
`endif

  w_burn_addr_ctr #(
    .N_BANK (N_BANK),
    .DEPTH  (DATA_DEPTH),
    .BANK_W (BANK_W),
    .ADDR_W (ADDR_W)
  ) u_ctr (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr_i  (ctr_clr),
    .inc_i  (ctr_inc),
    .bank_o (bank),
    .row_o  (row),
    .last_o (last)
  );

  // One-hot decode of the current bank position into a write strobe
  for (genvar gi = 0; gi < N_BANK; gi++) begin : g_we
    assign bank_oh[gi] = (bank == BANK_W'(gi));
  end

  // A session starts only on a fresh 0->1 of the enable level
  assign en_rise = burn_in_en && !en_q;

  // Next-state, write-port and status decode
  always_comb begin
    state_d   = state_q;
    burned_d  = burned_q;
    err_d     = err_q;
    we_d      = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    s_ready_w = 1'b0;
    ctr_clr   = 1'b0;
    ctr_inc   = 1'b0;
`ifdef W_BURN_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (en_rise) begin
          state_d  = LOAD;
          ctr_clr  = 1'b1;
          burned_d = 1'b0;
          err_d    = 1'b0;
`ifdef W_BURN_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (!burn_in_en) begin
          state_d  = IDLE;
          err_d    = 1'b1;
          burned_d = 1'b0;
        end else begin
          s_ready_w = 1'b1;
          if (bus.s_valid) begin
            we_d    = bank_oh;
            addr_d  = row;
            wdata_d = bus.s_data;
            ctr_inc = 1'b1;
`ifdef W_BURN_CHECKSUM_EN
            csum_d  = csum_q ^ bus.s_data;
            if (last) begin
              state_d = CHK;
            end
`else
            if (last) begin
              state_d  = DONE;
              burned_d = 1'b1;
            end
`endif
          end
        end
      end
`ifdef W_BURN_CHECKSUM_EN
      CHK: begin
        if (!burn_in_en) begin
          state_d  = IDLE;
          err_d    = 1'b1;
          burned_d = 1'b0;
        end else begin
          s_ready_w = 1'b1;
          if (bus.s_valid) begin
            state_d  = DONE;
            burned_d = (bus.s_data == csum_q);
            err_d    = (bus.s_data != csum_q);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, edge-detect, write port and status registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      burned_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= burn_in_en;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      burned_q <= burned_d;
      err_q    <= err_d;
    end
  end

`ifdef W_BURN_CHECKSUM_EN
  // Running XOR of all data beats in the current session
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign bus.s_ready   = s_ready_w;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q == LOAD) || (state_q == CHK);
  assign burned        = burned_q;
  assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_w_burn_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_w_burn_loader
// Purpose  : Self-checking bench for w_burn_loader, 4 banks x 8 rows.
// Revision : 1.0  initial release
// ============================================================================
module tb_w_burn_loader;

  localparam int DW    = 256;
  localparam int DD    = 8;
  localparam int NB    = 4;
  localparam int AW    = 3;
  localparam int NBEAT = NB * DD;
`ifdef W_BURN_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int TOT = NBEAT + (CSUM ? 1 : 0);
  // XOR of data values 0..31 is zero
  localparam logic [63:0] GOOD_TRAILER = 64'd0;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic burn_in_en = 1'b0;
  logic busy, burned, err;

  w_burn_loader_if #(.N_BANK(NB), .ADDR_W(AW)) bus ();

  w_burn_loader #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .burn_in_en (burn_in_en),
    .bus        (bus),
    .busy       (busy),
    .burned     (burned),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        v;
    logic [63:0] d;
    logic        e_ready;
    logic [3:0]  e_we;
    logic [2:0]  e_addr;
    logic [63:0] e_wdata;
    logic        e_busy;
    logic        e_burned;
    logic        e_err;
  } vec_t;

  vec_t vq[$];
  int tests = 0;
  int fails = 0;
  logic [63:0] img [NBEAT];

  // Fields: ready, we, addr, busy, burned, err, wdata
  function automatic logic [79:0] pack(input logic r, input logic [3:0] we, input logic [2:0] a,
                                       input logic bs, input logic br, input logic er,
                                       input logic [63:0] wd);
    return {5'b0, r, we, a, bs, br, er, wd};
  endfunction

  function automatic logic [79:0] act_pack(input bit wr);
    return pack(bus.s_ready, bus.mem_we, wr ? bus.mem_addr : 3'b0, busy, burned, err,
                wr ? bus.mem_wdata : 64'b0);
  endfunction

  task automatic check(input string nm, input int idx, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h required %h (rdy,we,addr,busy,burned,err,wdata)", nm, idx, act, exp);
    end
  endtask

  // k >= 0 means the write of beat index k (bank k%4, row k/4) with data wd is expected
  task automatic add(input bit en, input bit v, input int d, input bit r, input int k, input int wd,
                     input bit bsy, input bit brn, input bit er);
    vec_t x;
    x.en       = en;
    x.v        = v;
    x.d        = 64'(d);
    x.e_ready  = r;
    x.e_we     = (k >= 0) ? 4'(1 << (k % 4)) : 4'b0;
    x.e_addr   = (k >= 0) ? 3'(k / 4) : 3'b0;
    x.e_wdata  = (k >= 0) ? 64'(wd) : 64'b0;
    x.e_busy   = bsy;
    x.e_burned = brn;
    x.e_err    = er;
    vq.push_back(x);
  endtask

  task automatic run_table();
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      burn_in_en  = vq[i].en;
      bus.s_valid = vq[i].v;
      bus.s_data  = vq[i].d;
      @(negedge clk);
      check("vec", i, act_pack(vq[i].e_we != 4'b0),
            pack(vq[i].e_ready, vq[i].e_we, vq[i].e_addr, vq[i].e_busy, vq[i].e_burned,
                 vq[i].e_err, vq[i].e_wdata));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit vld;
    int sent;
    bit pacc;
    int pidx;
    int cyc;
    bit ok;
    logic       exp_ready;
    logic [3:0] exp_we;
    bit         exp_done;

    // ---- vector table: full burn, hold after DONE, restart, aborts ----
    add(1, 0, 0, 0, -1, 0, 0, 0, 0);
    for (int k = 0; k < NBEAT; k++) add(1, 1, k, 1, k - 1, k - 1, 1, 0, 0);
    if (!CSUM) begin
      add(1, 1, 99, 0, 31, 31, 0, 1, 0);
    end else begin
      add(1, 1, int'(GOOD_TRAILER), 1, 31, 31, 1, 0, 0);
    end
    add(1, 0, 0, 0, -1, 0, 0, 1, 0);
    for (int k = 0; k < 20; k++) add(1, 1, 55, 0, -1, 0, 0, 1, 0);
    add(0, 1, 55, 0, -1, 0, 0, 1, 0);
    add(1, 0, 0, 0, -1, 0, 0, 1, 0);
    add(1, 1, 200, 1, -1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 200, 1, 0, 0);
    add(0, 0, 0, 0, -1, 0, 0, 0, 1);
    add(1, 0, 0, 0, -1, 0, 0, 0, 1);
    for (int k = 0; k < 14; k++) add(1, 1, 300 + k, 1, k - 1, 300 + k - 1, 1, 0, 0);
    add(0, 1, 999, 0, 13, 313, 1, 0, 0);
    add(0, 0, 0, 0, -1, 0, 0, 0, 1);
    add(1, 0, 0, 0, -1, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) add(1, 1, 500 + k, 1, k - 1, 500 + k - 1, 1, 0, 0);

    // ---- reset state ----
    bus.s_valid = 1'b0;
    bus.s_data  = 64'd0;
    repeat (2) @(negedge clk);
    check("reset", 0, act_pack(1'b1), pack(0, 4'b0, 3'b0, 0, 0, 0, 64'b0));
    rst_b = 1'b1;

    run_table();

    // ---- async reset right after beat 6 is written ----
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    check("beat6_wr", 0, act_pack(1'b1), pack(1, 4'b0100, 3'd1, 1, 0, 0, 64'd506));
    #2;
    rst_b = 1'b0;
    #1;
    check("async_rst", 0, act_pack(1'b1), pack(0, 4'b0, 3'b0, 0, 0, 0, 64'b0));
    burn_in_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst", i, act_pack(1'b0), pack(0, 4'b0, 3'b0, 0, 0, 0, 64'b0));
    end

    // ---- random s_valid gaps ----
    for (int k = 0; k < NBEAT; k++) img[k] = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk);
    #1;
    burn_in_en = 1'b1;
    @(negedge clk);
    check("gap_idle", 0, act_pack(1'b0), pack(0, 4'b0, 3'b0, 0, 0, 0, 64'b0));
    sent = 0;
    pacc = 1'b0;
    pidx = 0;
    cyc  = 0;
    while ((sent < TOT || pacc) && cyc < 400) begin
      @(posedge clk);
      #1;
      vld = (sent < TOT) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.s_valid = vld;
      bus.s_data  = (sent < NBEAT) ? 64'(sent) : GOOD_TRAILER;
      @(negedge clk);
      exp_ready = (sent < TOT);
      exp_we    = (pacc && pidx < NBEAT) ? 4'(1 << (pidx % 4)) : 4'b0;
      exp_done  = pacc && (pidx == TOT - 1);
      check("gap", cyc, act_pack(exp_we != 4'b0),
            pack(exp_ready, exp_we, (exp_we != 4'b0) ? 3'(pidx / 4) : 3'b0, !exp_done, exp_done, 0,
                 (exp_we != 4'b0) ? 64'(pidx) : 64'b0));
      for (int b = 0; b < NB; b++) begin
        if (bus.mem_we[b]) img[int'(bus.mem_addr) * NB + b] = bus.mem_wdata;
      end
      pacc = vld && exp_ready;
      pidx = sent;
      if (pacc) sent++;
      cyc++;
    end
    if (cyc >= 400) begin
      tests++;
      fails++;
      $display("FAIL gap_timeout: got %0d beats accepted required %0d", sent, TOT);
    end
    ok = 1'b1;
    for (int k = 0; k < NBEAT; k++) if (img[k] !== 64'(k)) ok = 1'b0;
    check("image", 0, {79'b0, ok}, 80'd1);

`ifdef W_BURN_CHECKSUM_EN
    // ---- bad checksum trailer ----
    @(posedge clk);
    #1;
    burn_in_en  = 1'b0;
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    burn_in_en = 1'b1;
    for (int k = 0; k < NBEAT; k++) begin
      @(posedge clk);
      #1;
      bus.s_valid = 1'b1;
      bus.s_data  = 64'(k);
    end
    @(posedge clk);
    #1;
    bus.s_data = GOOD_TRAILER ^ 64'd1;
    @(negedge clk);
    check("chk_state", 0, act_pack(1'b1), pack(1, 4'b1000, 3'd7, 1, 0, 0, 64'd31));
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    @(negedge clk);
    check("csum_bad", 0, act_pack(1'b0), pack(0, 4'b0, 3'b0, 0, 0, 1, 64'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
